// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the clear-sequencer state type.
package regfile_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NRD   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_mp_reg_n.sv
// Single WIDTH-bit storage register with synchronous active-low reset and load enable.
module reg_n
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] R_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_q <= '0;
    end else if (Load) begin
      r_q <= D_in;
    end
  end

  assign R_out = r_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write forwarding and a
// sequential clear engine that zeroes one register per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Load,
  input  logic [AW-1:0]             DR,
  input  logic [WIDTH-1:0]          D_in,
  input  logic                      Clear,
  input  logic [NRD-1:0][AW-1:0]    SR,
  output logic [NRD-1:0][WIDTH-1:0] SR_Out,
  output logic [DEPTH-1:0]          Valid,
  output logic                      Busy,
  output logic                      Done
);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             busy;
  logic             wr_en;
  logic [WIDTH-1:0] reg_din;
  logic [DEPTH-1:0] hit_w, hit_c, reg_ld;
  logic [WIDTH-1:0] r_q [DEPTH];

  assign busy    = (state_q == CLEAR);
  assign wr_en   = Load & ~busy;
  // The shared register input carries zero while clearing; only the indexed register loads it.
  assign reg_din = busy ? '0 : D_in;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      assign hit_w[i]   = wr_en && (DR == AW'(i));
      assign hit_c[i]   = busy && (idx_q == AW'(i));
      assign reg_ld[i]  = hit_w[i] | hit_c[i];
      assign valid_d[i] = hit_c[i] ? 1'b0 : (hit_w[i] ? 1'b1 : valid_q[i]);

      reg_n #(.WIDTH(WIDTH)) u_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (reg_ld[i]),
        .D_in  (reg_din),
        .R_out (r_q[i])
      );
    end
  endgenerate

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [WIDTH-1:0] rd_raw;
      logic             fwd;
      assign rd_raw    = r_q[SR[p]];
      assign fwd       = (BYPASS != 0) && wr_en && (SR[p] == DR);
      assign SR_Out[p] = fwd ? D_in : rd_raw;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (Clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign Valid = valid_q;
  assign Busy  = busy;
  assign Done  = (state_q == DONE);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: one forwarding and one
// non-forwarding instance driven in lockstep against an array-based model.
module tb_regfile_mp;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int N  = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n = 1'b0;
  logic                  load  = 1'b0;
  logic                  clear = 1'b0;
  logic [AW-1:0]         dr    = '0;
  logic [W-1:0]          din   = '0;
  logic [N-1:0][AW-1:0]  sr    = '0;

  logic [N-1:0][W-1:0]   out_b, out_nb;
  logic [D-1:0]          vld_b, vld_nb;
  logic                  busy_b, busy_nb, done_b, done_nb;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(1)) dut_b (
    .Clk(clk), .Reset(rst_n), .Load(load), .DR(dr), .D_in(din), .Clear(clear),
    .SR(sr), .SR_Out(out_b), .Valid(vld_b), .Busy(busy_b), .Done(done_b)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(N), .BYPASS(0)) dut_nb (
    .Clk(clk), .Reset(rst_n), .Load(load), .DR(dr), .D_in(din), .Clear(clear),
    .SR(sr), .SR_Out(out_nb), .Valid(vld_nb), .Busy(busy_nb), .Done(done_nb)
  );

  // Reference model: register contents, valid flags and clear progress.
  logic [W-1:0] mem [D];
  bit           mvld [D];
  bit           clr_act;
  int           clr_pos;
  bit           done_f;

  typedef struct packed {
    logic [N-1:0][W-1:0] rd_b;
    logic [N-1:0][W-1:0] rd_nb;
    logic [D-1:0]        vld;
    logic                busy;
    logic                done;
  } exp_t;

  exp_t sbq [$];
  int   checks = 0;
  int   passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        mem[i]  = '0;
        mvld[i] = 1'b0;
      end
      clr_act = 1'b0;
      clr_pos = 0;
      done_f  = 1'b0;
    end else begin
      bit was_busy;
      was_busy = clr_act;
      if (load && !was_busy) begin
        mem[dr]  = din;
        mvld[dr] = 1'b1;
      end
      if (was_busy) begin
        mem[clr_pos]  = '0;
        mvld[clr_pos] = 1'b0;
        clr_pos++;
        if (clr_pos == D) begin
          clr_act = 1'b0;
          done_f  = 1'b1;
        end
      end else if (done_f) begin
        done_f = 1'b0;
      end else if (clear) begin
        clr_act = 1'b1;
        clr_pos = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit l, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input bit c,
                       input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    rst_n = r; load = l; dr = a; din = d; clear = c;
    sr[0] = s0; sr[1] = s1;
    for (int p = 0; p < N; p++) begin
      e.rd_nb[p] = mem[sr[p]];
      e.rd_b[p]  = (load && !clr_act && (sr[p] == dr)) ? din : mem[sr[p]];
    end
    for (int i = 0; i < D; i++) e.vld[i] = mvld[i];
    e.busy = clr_act;
    e.done = done_f;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(1, 0, 3'($urandom), 16'($urandom), 0, 3'($urandom), 3'($urandom));
  endtask

  task automatic fill();
    for (int i = 0; i < D; i++)
      drive(1, 1, 3'(i), W'(16'h1111 * (i + 1)), 0, 3'(i), 3'($urandom));
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rd_byp0",   32'(out_b[0]),  32'(e.rd_b[0]));
      chk("rd_byp1",   32'(out_b[1]),  32'(e.rd_b[1]));
      chk("rd_nobyp0", 32'(out_nb[0]), 32'(e.rd_nb[0]));
      chk("rd_nobyp1", 32'(out_nb[1]), 32'(e.rd_nb[1]));
      chk("valid",     32'(vld_b),     32'(e.vld));
      chk("valid_nb",  32'(vld_nb),    32'(e.vld));
      chk("busy",      32'(busy_b),    32'(e.busy));
      chk("busy_nb",   32'(busy_nb),   32'(e.busy));
      chk("done",      32'(done_b),    32'(e.done));
      chk("done_nb",   32'(done_nb),   32'(e.done));
    end
  end

  initial begin
    // Power-up reset, random prior state, then reset again.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      drive(1, 1, 3'($urandom), 16'($urandom), 0, 3'($urandom), 3'($urandom));
    drive(0, 1, 3'($urandom), 16'($urandom), 0, 3'($urandom), 3'($urandom));
    drive(1, 0, 0, 0, 0, 3'($urandom), 3'($urandom));

    // Single write, then both ports read it back.
    drive(1, 1, 3, 16'hBEEF, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 3, 3);

    // Same-cycle forwarding vs. old value.
    drive(1, 1, 5, 16'h1234, 0, 3, 5);
    drive(1, 0, 0, 0, 0, 5, 5);

    // Full clear with a write attempted in clear cycle 3.
    fill();
    drive(1, 0, 0, 0, 1, 0, 7);
    drive(1, 0, 0, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 0, 1, 2);
    drive(1, 1, 2, 16'hAAAA, 0, 2, 2);
    idle(9);
    drive(1, 0, 0, 0, 0, 2, 7);

    // Reset during clear cycle 4 abandons the sequence.
    fill();
    drive(1, 0, 0, 0, 1, 0, 7);
    idle(3);
    drive(0, 0, 0, 0, 0, 4, 7);
    idle(12);

    // Clear and Load together: write lands, then gets cleared.
    fill();
    drive(1, 1, 6, 16'hCAFE, 1, 6, 6);
    idle(12);

    // Randomised traffic with occasional clears and resets.
    for (int k = 0; k < 800; k++) begin
      logic [AW-1:0] a;
      a = 3'($urandom);
      drive(($urandom_range(0, 99) != 0), 1'($urandom), a, 16'($urandom),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0) ? a : 3'($urandom),
            ($urandom_range(0, 3) == 0) ? a : 3'($urandom));
    end
    idle(2);

    for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
    #1;
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
